// File: rtl/eth_mac_pkg.sv
`timescale 1ns/1ps
// eth_mac_pkg: Ethernet MAC constants, RX framer state encoding and the
// byte-wise reflected CRC-32 helper shared by the RX and TX paths.
package eth_mac_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY_REFL   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    END      = 3'd3,
    DROP     = 3'd4
  } rx_state_t;

  // Reflected CRC-32 advanced by one byte, LSB first, no final XOR.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
`timescale 1ns/1ps
// eth_crc32_byte: combinational next-CRC from current CRC and one byte.
module eth_crc32_byte
  import eth_mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_byte_update(crc_in, data_in);

endmodule

// File: rtl/eth_mac_rx_framer.sv
`timescale 1ns/1ps
// eth_mac_rx_framer: strips preamble/SFD, checks and removes the FCS, and
// emits frame bytes as an AXI-Stream source (no backpressure).
// Optional length checking is enabled by defining ETH_RX_LEN_CHECK_EN.
module eth_mac_rx_framer
  import eth_mac_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int PIPE_DEPTH    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_frame_good,
  output logic       stat_frame_bad,
  output logic       stat_crc_err
);

  localparam logic [2:0] S_IDLE     = 3'(IDLE);
  localparam logic [2:0] S_PREAMBLE = 3'(PREAMBLE);
  localparam logic [2:0] S_PAYLOAD  = 3'(PAYLOAD);
  localparam logic [2:0] S_END      = 3'(END);
  localparam logic [2:0] S_DROP     = 3'(DROP);
  localparam logic [2:0] PIPE_FULL  = 3'(PIPE_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [7:0]  pipe_q [PIPE_DEPTH];
  logic [7:0]  pipe_d [PIPE_DEPTH];
  logic [2:0]  pipe_cnt_q, pipe_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic        good_q, good_d, bad_q, bad_d, crc_err_q, crc_err_d;
  logic        crc_bad, len_bad, frame_bad;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data_in (rx_data),
    .crc_out (crc_next)
  );

`ifdef ETH_RX_LEN_CHECK_EN
  localparam logic [15:0] MIN_LEN16 = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_FRAME_LEN);
  logic [15:0] byte_cnt_q, byte_cnt_d;

  assign len_bad = (byte_cnt_q < MIN_LEN16) || (byte_cnt_q > MAX_LEN16);

  // Saturating count of bytes after the SFD, FCS included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) byte_cnt_q <= '0;
    else       byte_cnt_q <= byte_cnt_d;
  end
`else
  assign len_bad = 1'b0;
`endif

  assign crc_bad   = (crc_q != CRC32_RESIDUE);
  assign frame_bad = err_q | crc_bad | len_bad | (pipe_cnt_q != PIPE_FULL);

  // Framing FSM: next state, CRC, delay line and one-cycle output pulses
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    pipe_d     = pipe_q;
    pipe_cnt_d = pipe_cnt_q;
    err_d      = err_q;
    tdata_d    = 8'h00;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    crc_err_d  = 1'b0;
`ifdef ETH_RX_LEN_CHECK_EN
    byte_cnt_d = byte_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_en && rx_dv) begin
          state_d = (rx_data == ETH_PREAMBLE_BYTE) ? S_PREAMBLE : S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (rx_en) begin
          if (!rx_dv) begin
            state_d = S_IDLE;
          end else if (rx_er) begin
            state_d = S_DROP;
          end else if (rx_data == ETH_PREAMBLE_BYTE) begin
            state_d = S_PREAMBLE;
          end else if (rx_data == ETH_SFD_BYTE) begin
            state_d    = S_PAYLOAD;
            crc_d      = CRC32_INIT;
            pipe_cnt_d = '0;
            err_d      = 1'b0;
`ifdef ETH_RX_LEN_CHECK_EN
            byte_cnt_d = '0;
`endif
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_en && rx_dv) begin
          crc_d     = crc_next;
          pipe_d[0] = rx_data;
          for (int i = 1; i < PIPE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
          // Pipe full: the byte falling out the far end is known not to be FCS
          if (pipe_cnt_q == PIPE_FULL) begin
            tvalid_d = 1'b1;
            tdata_d  = pipe_q[PIPE_DEPTH-1];
          end else begin
            pipe_cnt_d = pipe_cnt_q + 3'd1;
          end
          if (rx_er) err_d = 1'b1;
`ifdef ETH_RX_LEN_CHECK_EN
          byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
          if (byte_cnt_d > MAX_LEN16) err_d = 1'b1;
`endif
        end else if (rx_en) begin
          // End of frame: the oldest pipe byte is the last data byte, rest is FCS
          if (pipe_cnt_q == PIPE_FULL) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = pipe_q[PIPE_DEPTH-1];
            tuser_d  = frame_bad;
          end
          good_d    = ~frame_bad;
          bad_d     = frame_bad;
          crc_err_d = crc_bad;
          state_d   = S_END;
        end
      end
      S_END: begin
        // Any byte arriving here is ignored; the next one is judged in IDLE
        pipe_cnt_d = '0;
        err_d      = 1'b0;
`ifdef ETH_RX_LEN_CHECK_EN
        byte_cnt_d = '0;
`endif
        state_d    = S_IDLE;
      end
      S_DROP: begin
        if (rx_en && !rx_dv) begin
          bad_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, CRC and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      crc_q      <= CRC32_INIT;
      pipe_cnt_q <= '0;
      err_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      pipe_cnt_q <= pipe_cnt_d;
      err_q      <= err_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      crc_err_q  <= crc_err_d;
    end
  end

  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
    // One stage of the byte delay line that hides the trailing FCS
    always_ff @(posedge clk or posedge reset) begin
      if (reset) pipe_q[gi] <= '0;
      else       pipe_q[gi] <= pipe_d[gi];
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign stat_frame_good = good_q;
  assign stat_frame_bad  = bad_q;
  assign stat_crc_err    = crc_err_q;

endmodule
